// File: rtl/muldiv_hilo_sequencer_if.sv
// EX-stage mult/div request and HI/LO access bundle.
interface muldiv_hilo_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             hilo_read;
   logic             hilo_sel;
   logic             hilo_write;
   logic [WIDTH-1:0] hilo_wdata;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hilo_data;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, operand_a, operand_b,
      output hilo_read, hilo_sel, hilo_write, hilo_wdata,
      input  stall, busy, done, hilo_data, hi, lo
   );

   modport slave (
      input  start, op, operand_a, operand_b,
      input  hilo_read, hilo_sel, hilo_write, hilo_wdata,
      output stall, busy, done, hilo_data, hi, lo
   );
endinterface

// File: rtl/muldiv_hilo_sequencer.sv
// Iterative shift-add multiply / restoring divide unit.
// Owns HI/LO and stalls EX on collisions with an op in flight.
module muldiv_hilo_sequencer #(
   parameter int WIDTH = 32
) (
   input logic                    clk,
   input logic                    reset,
   muldiv_hilo_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      RUN,
      FIX
   } state_t;

   state_t             state;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   m_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [2*WIDTH:0]   work;
   logic [CW-1:0]      cnt;
   logic               q_neg;
   logic               r_neg;
   logic               busy_q;
   logic               done_q;

   logic               is_div;
   logic               is_signed;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;

   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];
   assign a_neg     = is_signed & a_q[WIDTH-1];
   assign b_neg     = is_signed & b_q[WIDTH-1];
   assign abs_a     = a_neg ? -a_q : a_q;
   assign abs_b     = b_neg ? -b_q : b_q;

   // Multiply: conditional add into upper half, then shift right.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH:0]   mul_next;

   assign mul_sum  = work[2*WIDTH:WIDTH]
                   + (work[0] ? {1'b0, m_q} : '0);
   assign mul_next = {1'b0, mul_sum, work[WIDTH-1:1]};

   // Divide: remainder in upper WIDTH+1 bits, quotient shifts in below.
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic               ge;
   logic [2*WIDTH:0]   div_next;

   assign shifted  = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
   assign diff     = shifted - {1'b0, m_q};
   assign ge       = shifted >= {1'b0, m_q};
   assign div_next = {ge ? diff : shifted,
                      work[WIDTH-2:0], ge};

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               div_zero;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   assign prod     = work[2*WIDTH-1:0];
   assign prod_fix = q_neg ? -prod : prod;
   assign quo_fix  = q_neg ? -work[WIDTH-1:0]
                           : work[WIDTH-1:0];
   assign rem_fix  = r_neg ? -work[2*WIDTH-1:WIDTH]
                           : work[2*WIDTH-1:WIDTH];
   assign div_zero = (b_q == '0);

   always_comb begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
      if (is_div) begin
         fix_hi = div_zero ? a_q : rem_fix;
         fix_lo = div_zero ? '1 : quo_fix;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         work   <= '0;
         cnt    <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q   <= bus.op;
                  a_q    <= bus.operand_a;
                  b_q    <= bus.operand_b;
                  busy_q <= 1'b1;
                  state  <= PREP;
               end else if (bus.hilo_write) begin
                  if (bus.hilo_sel)
                     hi_q <= bus.hilo_wdata;
                  else
                     lo_q <= bus.hilo_wdata;
               end
            end
            PREP: begin
               m_q   <= is_div ? abs_b : abs_a;
               work  <= {{(WIDTH+1){1'b0}},
                         is_div ? abs_a : abs_b};
               q_neg <= a_neg ^ b_neg;
               r_neg <= a_neg;
               cnt   <= '0;
               state <= RUN;
            end
            RUN: begin
               work <= is_div ? div_next : mul_next;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  done_q <= 1'b1;
                  state  <= FIX;
               end
            end
            FIX: begin
               hi_q   <= fix_hi;
               lo_q   <= fix_lo;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.stall     = busy_q & (bus.start | bus.hilo_read
                                    | bus.hilo_write);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.hilo_data = bus.hilo_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// Scoreboard bench for muldiv_hilo_sequencer: directed ops,
// HI/LO access, stall behaviour and mid-operation reset.
module tb_muldiv_hilo_sequencer;
   logic clk;
   logic reset;

   muldiv_hilo_sequencer_if #(.WIDTH(32)) bus ();

   muldiv_hilo_sequencer #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!bus.busy) break;
      end
      if (k == 100) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_timeout: still busy after %0d cycles want idle",
                  name, k);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi,
                        input logic [31:0] lo, input string name,
                        input bit push);
      exp_t e;
      @(negedge clk);
      if (push) begin
         e.hi = hi;
         e.lo = lo;
         e.name = name;
         sb.push_back(e);
      end
      bus.start = 1'b1;
      bus.op = op;
      bus.operand_a = a;
      bus.operand_b = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op = ~op;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      chk({name, "_accepted"}, 64'(bus.busy), 64'd1);
   endtask

   // Monitor: counts busy cycles and checks HI/LO after each done pulse.
   initial begin
      int   bcnt;
      exp_t e;
      bcnt = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            bcnt = 0;
         end else begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
               chk("busy_cycles", 64'(bcnt), 64'd34);
               bcnt = 0;
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_done: got done want none");
               end else begin
                  e = sb.pop_front();
                  @(posedge clk);
                  #1;
                  chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
                  chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
                  chk({e.name, "_done_once"}, 64'(bus.done), 64'd0);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vecs[$];

   initial begin
      int k;
      int sc;
      bit sd;
      exp_t e;

      vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                       32'hFFFFFFFE, 32'h00000001, "multu_max"});
      vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'h00000005,
                       32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5"});
      vecs.push_back('{2'b00, 32'h80000000, 32'h80000000,
                       32'h40000000, 32'h00000000, "mult_minsq"});
      vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                       32'h00000000, 32'h00000001, "mult_m1xm1"});
      vecs.push_back('{2'b11, 32'd100, 32'd7,
                       32'd2, 32'd14, "divu_100_7"});
      vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'd2,
                       32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"});
      vecs.push_back('{2'b10, 32'd7, 32'hFFFFFFFE,
                       32'd1, 32'hFFFFFFFD, "div_7_m2"});
      vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF,
                       32'h00000000, 32'h80000000, "div_min_m1"});
      vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'd0,
                       32'hFFFFFFF9, 32'hFFFFFFFF, "div_by0"});
      vecs.push_back('{2'b11, 32'h1234, 32'd0,
                       32'h00001234, 32'hFFFFFFFF, "divu_by0"});

      reset = 1'b0;
      bus.start = 1'b0;
      bus.op = 2'b00;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.hilo_read = 1'b0;
      bus.hilo_sel = 1'b0;
      bus.hilo_write = 1'b0;
      bus.hilo_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_stall", 64'(bus.stall), 64'd0);

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].hi, vecs[i].lo, vecs[i].name, 1'b1);
         wait_idle(vecs[i].name);
      end

      // MTLO then MTHI while idle; reads are zero latency.
      @(negedge clk);
      bus.hilo_write = 1'b1;
      bus.hilo_sel = 1'b0;
      bus.hilo_wdata = 32'hCAFE;
      #1;
      chk("mtlo_stall", 64'(bus.stall), 64'd0);
      @(posedge clk);
      #1;
      chk("mtlo_lo", 64'(bus.lo), 64'h0000CAFE);
      chk("mtlo_hi_kept", 64'(bus.hi), 64'h00001234);
      @(negedge clk);
      bus.hilo_sel = 1'b1;
      bus.hilo_wdata = 32'hBEEF;
      @(negedge clk);
      bus.hilo_write = 1'b0;
      bus.hilo_read = 1'b1;
      #1;
      chk("mfhi_idle", 64'(bus.hilo_data), 64'h0000BEEF);
      bus.hilo_sel = 1'b0;
      #1;
      chk("mflo_idle", 64'(bus.hilo_data), 64'h0000CAFE);
      bus.hilo_read = 1'b0;

      // MFHI three cycles after a MULT start.
      issue(2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF,
            32'hFFFFFFF2, "mult_7xm2", 1'b1);
      repeat (2) @(negedge clk);
      bus.hilo_read = 1'b1;
      bus.hilo_sel = 1'b1;
      #1;
      sc = 0;
      sd = 1'b0;
      for (k = 0; k < 100 && bus.stall; k++) begin
         sc++;
         if (bus.done) sd = 1'b1;
         @(negedge clk);
         #1;
      end
      chk("mfhi_stall_cycles", 64'(sc), 64'd32);
      chk("mfhi_stall_in_fix", 64'(sd), 64'd1);
      chk("mfhi_unstalled_idle", 64'(bus.busy), 64'd0);
      chk("mfhi_new_hi", 64'(bus.hilo_data), 64'hFFFFFFFF);
      bus.hilo_read = 1'b0;

      // Second start presented while busy is held off until IDLE.
      issue(2'b11, 32'd1000, 32'd10, 32'd0, 32'd100,
            "divu_1000_10", 1'b1);
      repeat (2) @(negedge clk);
      e.hi = 32'd0;
      e.lo = 32'd12;
      e.name = "multu_3x4";
      sb.push_back(e);
      bus.start = 1'b1;
      bus.op = 2'b01;
      bus.operand_a = 32'd3;
      bus.operand_b = 32'd4;
      #1;
      sc = 0;
      for (k = 0; k < 100 && bus.stall; k++) begin
         sc++;
         @(negedge clk);
         #1;
      end
      chk("start_stall_cycles", 64'(sc), 64'd32);
      chk("start_released_idle", 64'(bus.busy), 64'd0);
      @(negedge clk);
      bus.start = 1'b0;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      chk("start_accepted", 64'(bus.busy), 64'd1);
      wait_idle("multu_3x4");

      // Asynchronous reset in RUN at counter 10.
      issue(2'b01, 32'd9, 32'd9, 32'd0, 32'd0, "multu_9x9", 1'b0);
      repeat (11) @(posedge clk);
      #2;
      bus.hilo_read = 1'b1;
      reset = 1'b0;
      #1;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      chk("abort_stall", 64'(bus.stall), 64'd0);
      chk("abort_hi", 64'(bus.hi), 64'd0);
      chk("abort_lo", 64'(bus.lo), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      bus.hilo_read = 1'b0;

      issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7", 1'b1);
      wait_idle("multu_6x7");

      repeat (5) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/muldiv_hilo_sequencer.md
Name: muldiv_hilo_sequencer

Overview:
- Multi-cycle multiply/divide unit and HI/LO register owner for the EX stage.
- Accepts MULT/MULTU/DIV/DIVU from EX; operands come from the forwarding muxes.
- Runs an iterative shift-add multiply or restoring divide.
- Stalls the pipeline while a MFHI/MFLO/MTHI/MTLO or a new mult/div would collide with an operation in flight.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits; RUN iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- startInput  in  1  EX holds a mult/div instruction this cycle.
- opInput  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with startInput.
- operandAInput  in  WIDTH  forwarded rs (multiplicand / dividend).
- operandBInput  in  WIDTH  forwarded rt (multiplier / divisor).
- hiLoReadInput  in  1  EX holds MFHI/MFLO.
- hiLoSelInput  in  1  0 = LO, 1 = HI; applies to both read and write.
- hiLoWriteInput  in  1  EX holds MTHI/MTLO.
- hiLoWriteDataInput  in  WIDTH  data for MTHI/MTLO.
- stallOutput  out  1  freeze IF/ID/EX, bubble into MEM.
- busyOutput  out  1  operation in flight.
- doneOutput  out  1  one-cycle pulse during FIX.
- hiLoDataOutput  out  WIDTH  combinational: HI if hiLoSelInput else LO.
- hiOutput  out  WIDTH  HI register.
- loOutput  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; HI=LO=0; counter, working registers and sign flags cleared.
  - busyOutput=0, doneOutput=0, stallOutput=0.
  - An operation in flight is aborted; HI/LO are not written.
- States:
  - IDLE -> PREP on startInput=1.
  - PREP -> RUN unconditionally. PREP takes absolute values for signed ops and records the quotient and remainder/product signs.
  - RUN performs WIDTH iterations (counter 0..WIDTH-1). On counter=WIDTH-1 it goes to FIX.
  - FIX applies sign correction, writes HI/LO at the end of the cycle, then goes to IDLE.
- Start handling:
  - The operands and op are captured at the edge that leaves IDLE. Later changes on the inputs are ignored.
- Latency:
  - The start edge is E0. HI/LO hold the new result after edge E(WIDTH+2), i.e. 34 edges for WIDTH=32.
  - busyOutput=1 in PREP, RUN and FIX (WIDTH+2 cycles).
  - doneOutput=1 only in FIX.
- Stall:
  - stallOutput = busyOutput AND (startInput OR hiLoReadInput OR hiLoWriteInput). It is combinational.
  - A stalled start is not accepted; the pipeline re-presents it.
  - MFHI/MFLO in the FIX cycle still stalls. Its first unstalled cycle (the next IDLE) reads the new value.
- IDLE register access:
  - hiLoWriteInput=1 writes hiLoWriteDataInput into HI or LO at the edge.
  - A read returns current contents with zero latency.
  - startInput and hiLoWriteInput together (illegal from the decoder): start wins, write dropped.
- Multiply results:
  - 2*WIDTH-bit product; HI = upper half, LO = lower half.
  - MULT is two's-complement signed; MULTU is unsigned.
- Divide results:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero (DIV or DIVU): LO = all ones, HI = operandA as captured; the full latency still applies.
  - DIV of most-negative by -1: LO = 0x80000000, HI = 0 (natural modulo-2^WIDTH wrap).
- No exception or overflow outputs.
- All internal arithmetic is at most 2*WIDTH+1 bits; no latches; all state flops on the async reset.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> busy for exactly 34 cycles, done pulses once, then HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (-3) * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIVU 100/7 -> LO=14, HI=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234 after 34 cycles. Then MTLO 0xCAFE while idle -> LO=0xCAFE next cycle, no stall.
- MFHI presented 3 cycles after a MULT start -> stallOutput high through FIX inclusive. On the first unstalled cycle, hiLoDataOutput equals the new HI. A second start during busy also stalls, then is accepted in IDLE.
- reset driven low in RUN at counter=10 -> immediately IDLE, busy/done/stall=0, HI=LO=0. After release, a new MULTU 6*7 gives LO=42, HI=0 after 34 cycles.
